// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: FSM encoding and channel geometry.
package demux_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_BUSY = 1'b1;
   localparam int   N_CH    = 4;
   localparam int   SEL_W   = 2;

   typedef enum logic {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY
   } state_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel.
// Loads a beat on load_i and drops valid once the beat has drained downstream.
module demux_out_slot #(
   parameter int DW = 8
) (
   input  logic          clk_in,
   input  logic          rst_in,
   input  logic          load_i,
   input  logic [DW-1:0] d_i,
   input  logic          last_i,
   input  logic          ready_i,
   output logic [DW-1:0] d_o,
   output logic          last_o,
   output logic          valid_o
);

   logic [DW-1:0] data_q, data_d;
   logic          last_q, last_d;
   logic          valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      last_d  = last_q;
      valid_d = valid_q;
      // A load in the same cycle as a drain wins, keeping valid high for back-to-back beats.
      if (load_i) begin
         data_d  = d_i;
         last_d  = last_i;
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         data_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign d_o     = data_q;
   assign last_o  = last_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer; the route is locked for a whole packet.
// Optional per-channel packet counters are enabled with `define DEMUX_1TO4_CNT_EN.
module demux_1to4_stream
   import demux_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [DW-1:0]       d_in,
   input  logic                last_in,
   input  logic                valid_in,
   output logic                ready_out,
   input  logic [SEL_W-1:0]    sel_in,
   output logic [N_CH*DW-1:0]  d_out,
   output logic [N_CH-1:0]     last_out,
   output logic [N_CH-1:0]     valid_out,
   input  logic [N_CH-1:0]     ready_in,
   output logic                busy_out
`ifdef DEMUX_1TO4_CNT_EN
   ,
   output logic [N_CH*8-1:0]   pkt_cnt_out
`endif
);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  route_q, route_d;
   logic [SEL_W-1:0]  route_s;
   logic              accept_s;
   logic [N_CH-1:0]   load_s;

   // ready_out is a combinational path from sel_in/ready_in by design.
   always_comb begin
      route_s   = (state_q == BUSY) ? route_q : sel_in;
      ready_out = ~valid_out[route_s] | ready_in[route_s];
      accept_s  = valid_in & ready_out;
      for (int k = 0; k < N_CH; k++) begin
         load_s[k] = accept_s && (route_s == SEL_W'(k));
      end
   end

   always_comb begin
      state_d = state_q;
      route_d = route_q;
      case (state_q)
         IDLE: begin
            if (accept_s && !last_in) begin
               state_d = BUSY;
               route_d = sel_in;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (accept_s && last_in) begin
               state_d = IDLE;
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         route_q <= '0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
      end
   end

   assign busy_out = (state_q == BUSY);

   for (genvar k = 0; k < N_CH; k++) begin : g_slot
      demux_out_slot #(.DW(DW)) u_slot (
         .clk_in  (clk_in),
         .rst_in  (rst_in),
         .load_i  (load_s[k]),
         .d_i     (d_in),
         .last_i  (last_in),
         .ready_i (ready_in[k]),
         .d_o     (d_out[k*DW +: DW]),
         .last_o  (last_out[k]),
         .valid_o (valid_out[k])
      );
   end

`ifdef DEMUX_1TO4_CNT_EN
   logic [N_CH*8-1:0] cnt_q;

   // Count completed packets per channel: a drained beat carrying last.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_q <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (valid_out[k] && ready_in[k] && last_out[k]) begin
               cnt_q[k*8 +: 8] <= cnt_q[k*8 +: 8] + 8'd1;
            end
         end
      end
   end

   assign pkt_cnt_out = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench: directed vector table, corner-case sequences, and a
// randomized phase checked against a queue-based channel model.
module tb_demux_1to4_stream;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [7:0]  d_in;
   logic        last_in;
   logic        valid_in;
   logic        ready_out;
   logic [1:0]  sel_in;
   logic [31:0] d_out;
   logic [3:0]  last_out;
   logic [3:0]  valid_out;
   logic [3:0]  ready_in;
   logic        busy_out;
`ifdef DEMUX_1TO4_CNT_EN
   logic [31:0] pkt_cnt_out;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk_in = ~clk_in;

   demux_1to4_stream #(.DW(8)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .d_in      (d_in),
      .last_in   (last_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .sel_in    (sel_in),
      .d_out     (d_out),
      .last_out  (last_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .busy_out  (busy_out)
`ifdef DEMUX_1TO4_CNT_EN
      ,
      .pkt_cnt_out (pkt_cnt_out)
`endif
   );

   typedef struct {
      logic        rst;
      logic        vin;
      logic [1:0]  sel;
      logic        last;
      logic [7:0]  d;
      logic [3:0]  rdy;
      logic        chk_rdy;
      logic        e_rdy;
      logic [3:0]  e_vout;
      logic [31:0] e_dout;
      logic [3:0]  e_lout;
      logic        e_busy;
   } vec_t;

   typedef logic [8:0] beat_t;

   vec_t  tbl[14];
   beat_t q[4][$];
   logic  m_busy;
   logic [1:0] m_route;
   logic [7:0] m_cnt[4];

   function automatic vec_t mk(input logic r, input logic v, input logic [1:0] s,
                               input logic l, input logic [7:0] d, input logic [3:0] rd,
                               input logic cr, input logic er, input logic [3:0] ev,
                               input logic [31:0] ed, input logic [3:0] el, input logic eb);
      vec_t t;
      t.rst = r; t.vin = v; t.sel = s; t.last = l; t.d = d; t.rdy = rd;
      t.chk_rdy = cr; t.e_rdy = er; t.e_vout = ev; t.e_dout = ed; t.e_lout = el; t.e_busy = eb;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [1:0] s,
                        input logic l, input logic [7:0] d, input logic [3:0] rd);
      rst_in = r; valid_in = v; sel_in = s; last_in = l; d_in = d; ready_in = rd;
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      logic [1:0] route;
      logic       exp_rdy;
      logic       acc;
      beat_t      b;

      drive(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tick();

      // reset, single-beat routing, packet lock, back-pressure
      tbl[0]  = mk(1'b1, 1'b1, 2'd0, 1'b0, 8'hFF, 4'hF, 1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 1'b0);
      tbl[1]  = mk(1'b1, 1'b1, 2'd0, 1'b0, 8'hFF, 4'hF, 1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 1'b0);
      tbl[2]  = mk(1'b1, 1'b1, 2'd0, 1'b0, 8'hFF, 4'hF, 1'b0, 1'b0, 4'b0000, 32'h00000000, 4'b0000, 1'b0);
      tbl[3]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b1, 1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b0);
      tbl[4]  = mk(1'b0, 1'b1, 2'd2, 1'b1, 8'hA5, 4'hF, 1'b1, 1'b1, 4'b0100, 32'h00A50000, 4'b0100, 1'b0);
      tbl[5]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 4'b0000, 32'h00A50000, 4'b0100, 1'b0);
      tbl[6]  = mk(1'b0, 1'b1, 2'd1, 1'b0, 8'h11, 4'hF, 1'b1, 1'b1, 4'b0010, 32'h00A51100, 4'b0100, 1'b1);
      tbl[7]  = mk(1'b0, 1'b1, 2'd3, 1'b0, 8'h22, 4'hF, 1'b1, 1'b1, 4'b0010, 32'h00A52200, 4'b0100, 1'b1);
      tbl[8]  = mk(1'b0, 1'b1, 2'd3, 1'b1, 8'h33, 4'hF, 1'b1, 1'b1, 4'b0010, 32'h00A53300, 4'b0110, 1'b0);
      tbl[9]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 4'b0000, 32'h00A53300, 4'b0110, 1'b0);
      tbl[10] = mk(1'b0, 1'b1, 2'd0, 1'b1, 8'h5A, 4'hE, 1'b1, 1'b1, 4'b0001, 32'h00A5335A, 4'b0111, 1'b0);
      tbl[11] = mk(1'b0, 1'b1, 2'd0, 1'b1, 8'h77, 4'hE, 1'b1, 1'b0, 4'b0001, 32'h00A5335A, 4'b0111, 1'b0);
      tbl[12] = mk(1'b0, 1'b1, 2'd3, 1'b1, 8'hC3, 4'hE, 1'b1, 1'b1, 4'b1001, 32'hC3A5335A, 4'b1111, 1'b0);
      tbl[13] = mk(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 1'b0, 1'b0, 4'b0000, 32'hC3A5335A, 4'b1111, 1'b0);

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].rst, tbl[i].vin, tbl[i].sel, tbl[i].last, tbl[i].d, tbl[i].rdy);
         #1;
         if (tbl[i].chk_rdy) chk($sformatf("vec%0d_ready", i), 32'(ready_out), 32'(tbl[i].e_rdy));
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(tbl[i].e_vout));
         chk($sformatf("vec%0d_data", i), d_out, tbl[i].e_dout);
         chk($sformatf("vec%0d_last", i), 32'(last_out), 32'(tbl[i].e_lout));
         chk($sformatf("vec%0d_busy", i), 32'(busy_out), 32'(tbl[i].e_busy));
      end

      // full throughput: 8 back-to-back beats to channel 3
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 2'd3, (i == 7), 8'(i), 4'hF);
         #1;
         chk("thru_ready", 32'(ready_out), 32'd1);
         tick();
         chk("thru_valid3", 32'(valid_out[3]), 32'd1);
         chk("thru_data3", 32'(d_out[31:24]), 32'(i));
      end
      drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
      tick();
      chk("thru_drain", 32'(valid_out), 32'd0);

      // mid-packet reset: two of four beats to channel 2, then reset
      drive(1'b0, 1'b1, 2'd2, 1'b0, 8'h01, 4'hF);
      tick();
      drive(1'b0, 1'b1, 2'd2, 1'b0, 8'h02, 4'hF);
      tick();
      chk("mid_busy_before", 32'(busy_out), 32'd1);
      drive(1'b1, 1'b1, 2'd2, 1'b0, 8'h03, 4'hF);
      tick();
      chk("mid_rst_valid", 32'(valid_out), 32'd0);
      chk("mid_rst_busy", 32'(busy_out), 32'd0);
      chk("mid_rst_data", d_out, 32'd0);
`ifdef DEMUX_1TO4_CNT_EN
      chk("mid_rst_cnt", pkt_cnt_out, 32'd0);
`endif
      drive(1'b0, 1'b1, 2'd0, 1'b1, 8'h99, 4'hF);
      tick();
      chk("post_rst_valid", 32'(valid_out), 32'h1);
      chk("post_rst_data0", 32'(d_out[7:0]), 32'h99);
      chk("post_rst_busy", 32'(busy_out), 32'd0);
      drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
      tick();
      chk("post_rst_data2", 32'(d_out[23:16]), 32'd0);
`ifdef DEMUX_1TO4_CNT_EN
      chk("cnt0_one", 32'(pkt_cnt_out[7:0]), 32'd1);
      for (int i = 0; i < 255; i++) begin
         drive(1'b0, 1'b1, 2'd1, 1'b1, 8'(i), 4'hF);
         tick();
      end
      drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
      tick();
      chk("cnt1_255", 32'(pkt_cnt_out[15:8]), 32'd255);
      drive(1'b0, 1'b1, 2'd1, 1'b1, 8'hEE, 4'hF);
      tick();
      drive(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'hF);
      tick();
      chk("cnt1_wrap", 32'(pkt_cnt_out[15:8]), 32'd0);
`endif

      // randomized phase against the channel-queue model
      drive(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         q[k].delete();
         m_cnt[k] = 8'd0;
      end
      m_busy  = 1'b0;
      m_route = 2'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         drive(1'b0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 2) == 0), 8'($urandom),
               {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
         #1;
         route   = m_busy ? m_route : sel_in;
         exp_rdy = (q[route].size() == 0) || ready_in[route];
         chk("rand_ready", 32'(ready_out), 32'(exp_rdy));
         acc = valid_in && exp_rdy;
         @(posedge clk_in);
         for (int k = 0; k < 4; k++) begin
            if (q[k].size() != 0 && ready_in[k]) begin
               b = q[k].pop_front();
               if (b[8]) m_cnt[k] = m_cnt[k] + 8'd1;
            end
         end
         if (acc) begin
            q[route].push_back({last_in, d_in});
            if (!m_busy && !last_in) begin
               m_busy  = 1'b1;
               m_route = sel_in;
            end else if (m_busy && last_in) begin
               m_busy = 1'b0;
            end
         end
         #1;
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("rand_valid%0d", k), 32'(valid_out[k]), 32'(q[k].size() != 0));
            if (q[k].size() != 0) begin
               b = q[k][0];
               chk($sformatf("rand_data%0d", k), 32'(d_out[k*8 +: 8]), 32'(b[7:0]));
               chk($sformatf("rand_last%0d", k), 32'(last_out[k]), 32'(b[8]));
            end
`ifdef DEMUX_1TO4_CNT_EN
            chk($sformatf("rand_cnt%0d", k), 32'(pkt_cnt_out[k*8 +: 8]), 32'(m_cnt[k]));
`endif
         end
         chk("rand_busy", 32'(busy_out), 32'(m_busy));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
